ll_window_acc: RTL and testbench
================================

LL_WINDOW_ACC -- requirements
Module: ll_window_acc

Interface
- REQ-001: Parameter input_width, default 32: sample width of the upstream difference unit; din is input_width+1 bits.
- REQ-002: Parameter win_len, default 16: window length in samples; power of two, 2..256.
- REQ-003: Parameter sum_width, default input_width+log2(win_len): width of ll_sum; no smaller value is permitted.
- REQ-004: clk  input  1  sole clock; all state updates on rising edge.
- REQ-005: rst  input  1  reset, asynchronous, active-high.
- REQ-006: din  input  input_width+1  signed |x[i]-x[i-1]| from the difference unit.
- REQ-007: din_valid  input  1  active-high; din is a new sample this cycle.
- REQ-008: clr  input  1  synchronous flush of window, active-high.
- REQ-009: thresh  input  sum_width  unsigned detection threshold, sampled every cycle.
- REQ-010: ll_sum  output  sum_width  unsigned line-length sum of the last win_len accepted samples.
- REQ-011: sum_valid  output  1  high once the window holds win_len samples.
- REQ-012: detect  output  1  high when sum_valid and ll_sum > thresh.
- REQ-013: fill_cnt  output  log2(win_len)+1  number of samples currently in the window, 0..win_len.

Function
- REQ-014: Sample magnitude SHALL be din[input_width-1:0] as unsigned; din[input_width] is ignored.
- REQ-015: The block SHALL hold a circular buffer of win_len magnitudes with a write pointer wr_ptr of log2(win_len) bits.
- REQ-016: On a cycle with din_valid=1 and clr=0, the block SHALL write the magnitude at wr_ptr and increment wr_ptr, wrapping from win_len-1 to 0.
- REQ-017: On the same cycle, the running sum SHALL be updated to sum + new - old, where old = buffer[wr_ptr] in state RUN and 0 in state FILL.
- REQ-018: ll_sum, sum_valid, detect and fill_cnt SHALL be registered; they reflect an accepted sample on the cycle after it is accepted (latency 1).
- REQ-019: detect SHALL be computed from the updated sum and the thresh value present on the accepting cycle; it is re-evaluated every cycle with the current thresh while no sample arrives.
- REQ-020: State machine, two states. FILL: fill_cnt < win_len, sum_valid=0, detect=0. RUN: fill_cnt = win_len, sum_valid=1.
- REQ-021: FILL->RUN SHALL occur on acceptance of the win_len-th sample; ll_sum then equals the sum of all win_len samples.
- REQ-022: RUN->FILL SHALL occur only on clr or rst.
- REQ-023: In RUN, fill_cnt SHALL saturate at win_len.
- REQ-024: With din_valid=0, all outputs and all stored state SHALL hold.
- REQ-025: clr=1 SHALL set sum, fill_cnt and wr_ptr to 0 and enter FILL on the next edge; din_valid in the same cycle is discarded.
- REQ-026: Buffer contents need not be cleared by clr or rst, because FILL never reads them.
- REQ-027: The sum arithmetic SHALL be unsigned and exact; no overflow can occur at the required sum_width.
- REQ-028: An X or negative-signed din SHALL NOT corrupt the state when din_valid=0.

Reset
- REQ-029: rst=1 SHALL asynchronously set ll_sum=0, sum_valid=0, detect=0, fill_cnt=0, wr_ptr=0 and state FILL.
- REQ-030: rst asserted mid-window SHALL discard all accumulated samples; the first sample after release starts a new window.
- REQ-031: rst SHALL take priority over clr and din_valid.

Verification (win_len=4, input_width=8)
- REQ-032: Reset, then samples 1,2,3,4 on consecutive cycles -> ll_sum 1,3,6,10; sum_valid rises with ll_sum=10; fill_cnt reaches 4.
- REQ-033: Continue with samples 5,6 -> ll_sum 14 then 18; wr_ptr wraps; sum_valid stays 1.
- REQ-034: din_valid toggled 1,0,0,1 with samples 7,x,x,9 -> outputs hold through the gaps; sums are correct across the bubbles.
- REQ-035: thresh=17 with window {3,4,5,6}=18 -> detect=1; next sample 0 gives ll_sum=15 -> detect=0; in FILL with thresh=0 -> detect=0.
- REQ-036: Four samples of 255 -> ll_sum=1020, no overflow; din sign bit set with magnitude 5 -> 5 added.
- REQ-037: clr together with din_valid in RUN -> next cycle ll_sum=0, fill_cnt=0, sum_valid=0; rst pulse mid-clock -> outputs 0 before the next edge.

Source files
------------

// File: rtl/ll_window_acc.sv
// Sliding-window line-length accumulator: keeps a running sum of the last
// win_len sample magnitudes and flags when that sum exceeds a threshold.
module ll_window_acc #(
    parameter int unsigned input_width = 32,
    parameter int unsigned win_len     = 16,
    parameter int unsigned sum_width   = input_width + $clog2(win_len)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [input_width:0]       din,
    input  logic                       din_valid,
    input  logic                       clr,
    input  logic [sum_width-1:0]       thresh,
    output logic [sum_width-1:0]       ll_sum,
    output logic                       sum_valid,
    output logic                       detect,
    output logic [$clog2(win_len):0]   fill_cnt
);

    localparam int unsigned ptr_w = $clog2(win_len);
    localparam logic [ptr_w:0] full_cnt = (ptr_w + 1)'(win_len);

    typedef enum logic [0:0] {StFill, StRun} state_e;

    state_e                 state_q, state_d;
    logic [sum_width-1:0]   sum_q, sum_d;
    logic [ptr_w:0]         fill_q, fill_d;
    logic [ptr_w-1:0]       wr_ptr_q, wr_ptr_d;
    logic                   detect_q, detect_d;
    logic [input_width-1:0] mem_q [win_len];

    logic [input_width-1:0] mag;
    logic [input_width-1:0] old_mag;
    logic                   accept;

    // Next-state: flush on clr, otherwise slide the window on each accepted sample.
    always_comb begin
        mag      = din[input_width-1:0];
        // Slots are only read once the window is full, so stale contents never leak in.
        old_mag  = (state_q == StRun) ? mem_q[wr_ptr_q] : '0;
        accept   = din_valid && !clr;
        state_d  = state_q;
        sum_d    = sum_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        if (clr) begin
            state_d  = StFill;
            sum_d    = '0;
            fill_d   = '0;
            wr_ptr_d = '0;
        end else if (din_valid) begin
            sum_d    = sum_q + sum_width'(mag) - sum_width'(old_mag);
            wr_ptr_d = wr_ptr_q + ptr_w'(1);
            if (state_q == StFill) begin
                fill_d = fill_q + (ptr_w + 1)'(1);
                if (fill_d == full_cnt) begin
                    state_d = StRun;
                end
            end
        end
        // Threshold is re-sampled every cycle, even without a new sample.
        detect_d = (state_d == StRun) && (sum_d > thresh);
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StFill;
            sum_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            detect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            detect_q <= detect_d;
        end
    end

    // Sample buffer; no reset needed since FILL never reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= mag;
        end
    end

    assign ll_sum    = sum_q;
    assign sum_valid = (state_q == StRun);
    assign detect    = detect_q;
    assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_ll_window_acc.sv
// Bench for ll_window_acc: directed literal checks plus randomized traffic
// compared every cycle against a queue-based window model.
module tb_ll_window_acc;

    localparam int unsigned IW = 8;
    localparam int unsigned WL = 4;
    localparam int unsigned SW = IW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW:0]   din = '0;
    logic          din_valid = 1'b0;
    logic          clr = 1'b0;
    logic [SW-1:0] thresh = '0;
    logic [SW-1:0] ll_sum;
    logic          sum_valid;
    logic          detect;
    logic [2:0]    fill_cnt;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    int win_q[$];
    int m_sum = 0;
    int m_fill = 0;
    bit m_valid = 1'b0;
    bit m_detect = 1'b0;

    ll_window_acc #(
        .input_width(IW),
        .win_len    (WL),
        .sum_width  (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .clr      (clr),
        .thresh   (thresh),
        .ll_sum   (ll_sum),
        .sum_valid(sum_valid),
        .detect   (detect),
        .fill_cnt (fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window model: the last WL accepted magnitudes, summed directly.
    always @(posedge clk or posedge rst) begin
        int s;
        if (rst || clr) begin
            win_q.delete();
        end else if (din_valid) begin
            win_q.push_back(int'(din[IW-1:0]));
            if (win_q.size() > WL) void'(win_q.pop_front());
        end
        s = 0;
        foreach (win_q[i]) s += win_q[i];
        m_sum    <= s;
        m_fill   <= win_q.size();
        m_valid  <= (win_q.size() == WL);
        m_detect <= !rst && (win_q.size() == WL) && (s > int'(thresh));
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_sum", int'(ll_sum), m_sum);
            chk("model_fill", int'(fill_cnt), m_fill);
            chk("model_valid", int'(sum_valid), int'(m_valid));
            chk("model_detect", int'(detect), int'(m_detect));
        end
    end

    // Drive one cycle of inputs; returns 2 time units after the consuming edge.
    task automatic cyc(input bit v, input int d, input bit c, input int t);
        din_valid = v;
        din       = (IW + 1)'(d);
        clr       = c;
        thresh    = SW'(t);
        @(posedge clk);
        #2;
    endtask

    task automatic chk_out(input string name, input int s, input int f, input int v,
                           input int det);
        chk({name, "_sum"}, int'(ll_sum), s);
        chk({name, "_fill"}, int'(fill_cnt), f);
        chk({name, "_valid"}, int'(sum_valid), v);
        chk({name, "_detect"}, int'(detect), det);
    endtask

    initial begin
        rst = 1'b1;
        #1;
        cmp_en = 1'b1;
        chk_out("reset", 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Fill and slide.
        cyc(1, 1, 0, 1000); chk_out("s1", 1, 1, 0, 0);
        cyc(1, 2, 0, 1000); chk_out("s2", 3, 2, 0, 0);
        cyc(1, 3, 0, 1000); chk_out("s3", 6, 3, 0, 0);
        cyc(1, 4, 0, 1000); chk_out("s4", 10, 4, 1, 0);
        cyc(1, 5, 0, 1000); chk_out("s5", 14, 4, 1, 0);
        cyc(1, 6, 0, 17);   chk_out("s6_detect", 18, 4, 1, 1);
        cyc(1, 0, 0, 17);   chk_out("s0_nodetect", 15, 4, 1, 0);

        // Bubbles: {5,6,0,7}=18 held, then {6,0,7,9}=22.
        cyc(1, 7, 0, 17);    chk_out("b7", 18, 4, 1, 1);
        cyc(0, 9'h1ff, 0, 17); chk_out("gap1", 18, 4, 1, 1);
        cyc(0, 9'h0aa, 0, 17); chk_out("gap2", 18, 4, 1, 1);
        cyc(1, 9, 0, 17);    chk_out("b9", 22, 4, 1, 1);
        cyc(0, 0, 0, 30);    chk_out("thr_reeval", 22, 4, 1, 0);

        // Full-scale samples, then sign bit ignored.
        for (int i = 0; i < 4; i++) cyc(1, 255, 0, 1019);
        chk_out("max", 1020, 4, 1, 1);
        cyc(1, 9'h105, 0, 1019); chk_out("signbit", 770, 4, 1, 0);

        // clr with a sample in RUN discards the sample.
        cyc(1, 50, 1, 0); chk_out("clr", 0, 0, 0, 0);
        cyc(1, 3, 0, 0);  chk_out("fill_thr0", 3, 1, 0, 0);

        // Mid-cycle reset pulse.
        rst = 1'b1;
        #1;
        chk_out("rst_async", 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc(1, 11, 0, 0); chk_out("after_rst", 11, 1, 0, 0);

        // Randomized traffic checked by the compare process.
        for (int n = 0; n < 3000; n++) begin
            din_valid = ($urandom_range(0, 3) != 0);
            din       = (IW + 1)'($urandom);
            clr       = ($urandom_range(0, 40) == 0);
            thresh    = SW'($urandom_range(0, 1023));
            rst       = ($urandom_range(0, 300) == 0);
            @(posedge clk);
            #2;
        end
        rst       = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
